// File: rtl/i2c_master_ctrl.sv
// Single-master I2C sequencer for one-byte register writes and reads.
// SCL/SDA are open-drain: the *_oe outputs pull a line low, the pullup lives outside.
module i2c_master_ctrl #(
    parameter int unsigned CLK_DIV = 250,
    parameter int unsigned REG_W   = 8,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [6:0]        req_dev,
    input  logic [REG_W-1:0]  req_reg,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_nack,
    output logic              busy,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              scl_oe,
    output logic              sda_oe
);

    localparam int unsigned SW = (REG_W > DATA_W) ? ((REG_W > 8) ? REG_W : 8)
                                                  : ((DATA_W > 8) ? DATA_W : 8);
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BW = $clog2(SW + 1);
    localparam logic [CW-1:0] CntMax = CW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        StIdle, StStart, StDevW, StAckA, StReg, StAckR, StWdata, StAckD,
        StRstart, StDevR, StAckA2, StRdata, StMnack, StStop, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        qtr_q, qtr_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [SW-1:0]     tx_q, tx_d;
    logic              rw_q, rw_d;
    logic [6:0]        dev_q, dev_d;
    logic [REG_W-1:0]  reg_q, reg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              nack_q, nack_d;
    logic              rsp_valid_q;
    logic              scl_oe_q, sda_oe_q;
    logic [1:0]        line_d;

    logic hold, tick, sample, slot_end, byte_last, is_ack;

    // {scl_low, sda_low} for a given slot position; bit is the data bit being sent.
    function automatic logic [1:0] line_levels(state_e st, logic [1:0] q, logic b);
        logic [1:0] lv;
        case (st)
            StIdle, StDone:                    lv = 2'b00;
            StStart:                           lv = {1'b0, q[1]};
            StRstart:                          lv = {q == 2'd0, q[1]};
            StStop:                            lv = {q == 2'd0, q != 2'd3};
            StDevW, StReg, StWdata, StDevR:    lv = {!q[1], !b};
            default:                           lv = {!q[1], 1'b0};
        endcase
        return lv;
    endfunction

    assign req_ready = (state_q == StIdle) && !rst;
    assign busy      = (state_q != StIdle) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_nack  = nack_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;

    // The divider freezes in the high phase while a slave stretches the clock.
    assign hold     = (qtr_q == 2'd2) && !scl_in;
    assign tick     = !hold && (cnt_q == CntMax);
    assign sample   = tick && (qtr_q == 2'd2);
    assign slot_end = tick && (qtr_q == 2'd3);
    assign is_ack   = (state_q == StAckA) || (state_q == StAckR) ||
                      (state_q == StAckD) || (state_q == StAckA2);

    always_comb begin
        case (state_q)
            StReg:            byte_last = (bit_q == BW'(REG_W - 1));
            StWdata, StRdata: byte_last = (bit_q == BW'(DATA_W - 1));
            default:          byte_last = (bit_q == BW'(7));
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rw_d    = rw_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        nack_d  = nack_q;

        case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    rw_d    = req_rw;
                    dev_d   = req_dev;
                    reg_d   = req_reg;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    nack_d  = 1'b0;
                    cnt_d   = '0;
                    qtr_d   = 2'd0;
                    state_d = StStart;
                end
            end
            StDone: state_d = StIdle;
            default: begin
                if (!hold) begin
                    if (cnt_q == CntMax) begin
                        cnt_d = '0;
                        qtr_d = qtr_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (sample) begin
                    if (is_ack && sda_in) nack_d = 1'b1;
                    if (state_q == StRdata) rdata_d = (rdata_q << 1) | DATA_W'(sda_in);
                end
                if (slot_end) begin
                    bit_d = bit_q + 1'b1;
                    tx_d  = tx_q << 1;
                    case (state_q)
                        StStart: begin
                            state_d = StDevW;
                            tx_d    = SW'({dev_q, 1'b0}) << (SW - 8);
                        end
                        StDevW:  if (byte_last) state_d = StAckA;
                        StAckA: begin
                            state_d = nack_q ? StStop : StReg;
                            tx_d    = SW'(reg_q) << (SW - REG_W);
                        end
                        StReg:   if (byte_last) state_d = StAckR;
                        StAckR: begin
                            state_d = nack_q ? StStop : (rw_q ? StRstart : StWdata);
                            tx_d    = SW'(wdata_q) << (SW - DATA_W);
                        end
                        StWdata: if (byte_last) state_d = StAckD;
                        StAckD:  state_d = StStop;
                        StRstart: begin
                            state_d = StDevR;
                            tx_d    = SW'({dev_q, 1'b1}) << (SW - 8);
                        end
                        StDevR:  if (byte_last) state_d = StAckA2;
                        StAckA2: state_d = nack_q ? StStop : StRdata;
                        StRdata: if (byte_last) state_d = StMnack;
                        StMnack: state_d = StStop;
                        StStop:  state_d = StDone;
                        default: state_d = StIdle;
                    endcase
                    if (state_d != state_q) bit_d = '0;
                end
            end
        endcase

        // Line enables are registered from next-state values so they change with the slot.
        line_d = line_levels(state_d, qtr_d, tx_d[SW-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            qtr_q       <= 2'd0;
            bit_q       <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            dev_q       <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            nack_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            nack_q      <= nack_d;
            rsp_valid_q <= (state_q == StDone);
            scl_oe_q    <= line_d[1];
            sda_oe_q    <= line_d[0];
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: behavioural I2C slave on a wired-AND bus, a slot-count
// reference model feeding a scoreboard queue, and a monitor checking each response.
module tb_i2c_master_ctrl;

    localparam int unsigned CLK_DIV  = 4;
    localparam logic [6:0]  SLAVE_ID = 7'h50;
    localparam int          SLOT     = 4 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [6:0] req_dev = '0;
    logic [7:0] req_reg = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       busy;
    logic       scl_in, sda_in, scl_oe, sda_oe;
    logic       stretch = 1'b0;
    logic       s_sda_low;

    wire scl_bus = !(scl_oe || stretch);
    wire sda_bus = !(sda_oe || s_sda_low);
    assign scl_in = scl_bus;
    assign sda_in = sda_bus;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .REG_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_dev(req_dev),
        .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .busy(busy),
        .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural slave + bus condition counters ----------------
    logic [7:0] s_mem [256];
    logic [7:0] s_sh, s_ptr, s_rbyte;
    logic       scl_p = 1'b1, sda_p = 1'b1, s_ack = 1'b0, mem_init = 1'b0;
    int         s_phase = 0;  // 0 idle, 1 addr, 2 reg, 3 wdata, 4 rdata, 5 ignore
    int         s_bits = 0;
    int         start_cnt = 0, stop_cnt = 0;

    initial s_sda_low = 1'b0;

    always @(posedge clk) begin
        scl_p <= scl_bus;
        sda_p <= sda_bus;
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) s_mem[i] <= 8'(i) ^ 8'h5A;
            mem_init <= 1'b1;
        end
        if (rst) begin
            s_phase <= 0; s_bits <= 0; s_ack <= 1'b0; s_sda_low <= 1'b0;
        end else if (scl_p && scl_bus && sda_p && !sda_bus) begin
            start_cnt <= start_cnt + 1;
            s_phase <= 1; s_bits <= 0; s_sh <= '0; s_ack <= 1'b0; s_sda_low <= 1'b0;
        end else if (scl_p && scl_bus && !sda_p && sda_bus) begin
            stop_cnt <= stop_cnt + 1;
            s_phase <= 0; s_ack <= 1'b0; s_sda_low <= 1'b0;
        end else if (!scl_p && scl_bus) begin
            if (s_phase inside {1, 2, 3} && !s_ack && s_bits < 8) begin
                s_sh   <= {s_sh[6:0], sda_bus};
                s_bits <= s_bits + 1;
            end
        end else if (scl_p && !scl_bus) begin
            if (s_ack) begin
                s_ack  <= 1'b0;
                s_bits <= 0;
                if (s_phase == 4) begin
                    s_sda_low <= !s_rbyte[7];
                    s_rbyte   <= s_rbyte << 1;
                    s_bits    <= 1;
                end else begin
                    s_sda_low <= 1'b0;
                end
            end else if (s_phase inside {1, 2, 3} && s_bits == 8) begin
                if (s_phase == 1) begin
                    if (s_sh[7:1] == SLAVE_ID) begin
                        s_ack <= 1'b1; s_sda_low <= 1'b1;
                        if (s_sh[0]) begin s_phase <= 4; s_rbyte <= s_mem[s_ptr]; end
                        else s_phase <= 2;
                    end else begin
                        s_phase <= 5;
                    end
                end else if (s_phase == 2) begin
                    s_ptr <= s_sh; s_ack <= 1'b1; s_sda_low <= 1'b1; s_phase <= 3;
                end else begin
                    s_mem[s_ptr] <= s_sh; s_ack <= 1'b1; s_sda_low <= 1'b1; s_phase <= 5;
                end
            end else if (s_phase == 4) begin
                if (s_bits < 8) begin
                    s_sda_low <= !s_rbyte[7];
                    s_rbyte   <= s_rbyte << 1;
                    s_bits    <= s_bits + 1;
                end else begin
                    s_sda_low <= 1'b0;
                    s_phase   <= 5;
                end
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [7:0] rdata;
        logic       nack;
        int         lat;
        int         acc;
    } exp_t;

    exp_t       q_exp[$];
    logic [7:0] ref_mem [256];

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid) begin
            if (q_exp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected rsp_valid: got pulse at cycle %0d, want none", cyc);
            end else begin
                e = q_exp.pop_front();
                chk("rsp_rdata", int'(rsp_rdata), int'(e.rdata));
                chk("rsp_nack", int'(rsp_nack), int'(e.nack));
                chk("latency", cyc - e.acc, e.lat);
            end
        end
    end

    // Presents a request, waits for acceptance and (optionally) queues the model's answer.
    task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input int extra, input bit expect_rsp,
                         output int acc);
        exp_t e;
        bit   present;
        @(negedge clk);
        req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
        for (int i = 0; i < 4000 && !req_ready; i++) @(negedge clk);
        chk("accept", int'(req_ready), 1);
        acc = cyc;
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        present = (dev == SLAVE_ID);
        if (expect_rsp) begin
            if (present && !rw) ref_mem[rg] = wd;
            e.rdata = (present && rw) ? ref_mem[rg] : 8'h00;
            e.nack  = !present;
            e.lat   = (present ? (rw ? 39 : 29) : 11) * SLOT + 2 + extra;
            e.acc   = acc;
            q_exp.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && (q_exp.size() != 0 || busy); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("drained", q_exp.size(), 0);
    endtask

    int a, a2, st0, sp0;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst req_ready", int'(req_ready), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst scl_oe", int'(scl_oe), 0);
        chk("rst sda_oe", int'(sda_oe), 0);
        chk("rst rsp_valid", int'(rsp_valid), 0);
        rst = 1'b0;
        #1 chk("idle req_ready", int'(req_ready), 1);

        // 1: write, 2: read back with Sr
        st0 = start_cnt; sp0 = stop_cnt;
        issue(1'b0, SLAVE_ID, 8'hCD, 8'hA5, 0, 1'b1, a);
        wait_idle();
        chk("t1 slave mem", int'(s_mem[8'hCD]), 8'hA5);
        chk("t1 starts", start_cnt - st0, 1);
        st0 = start_cnt; sp0 = stop_cnt;
        issue(1'b1, SLAVE_ID, 8'hCD, 8'h00, 0, 1'b1, a);
        wait_idle();
        chk("t2 starts incl Sr", start_cnt - st0, 2);
        chk("t2 stops", stop_cnt - sp0, 1);

        // 3: absent device
        sp0 = stop_cnt;
        issue(1'b0, 7'h23, 8'hCD, 8'h99, 0, 1'b1, a);
        wait_idle();
        chk("t3 stop", stop_cnt - sp0, 1);
        chk("t3 mem kept", int'(s_mem[8'hCD]), 8'hA5);

        // 4: stretch 37 cycles in DEVW bit 3 (slot 4, high phase starts a+73)
        issue(1'b0, SLAVE_ID, 8'h44, 8'h3C, 37, 1'b1, a);
        while (cyc < a + 71) @(negedge clk);
        stretch = 1'b1;
        while (cyc < a + 110) @(negedge clk);
        stretch = 1'b0;
        wait_idle();
        chk("t4 slave mem", int'(s_mem[8'h44]), 8'h3C);

        // 5: reset mid REG bit 5 (slot 15)
        issue(1'b0, SLAVE_ID, 8'h66, 8'hEE, 0, 1'b0, a);
        while (cyc < a + 247) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5 scl_oe", int'(scl_oe), 0);
        chk("t5 sda_oe", int'(sda_oe), 0);
        chk("t5 busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("t5 req_ready", int'(req_ready), 1);
        repeat (700) @(negedge clk);
        chk("t5 mem kept", int'(s_mem[8'h66]), int'(8'h66 ^ 8'h5A));
        issue(1'b0, SLAVE_ID, 8'h10, 8'h77, 0, 1'b1, a);
        wait_idle();
        chk("t5 next write", int'(s_mem[8'h10]), 8'h77);

        // 6: second request held while busy
        issue(1'b0, SLAVE_ID, 8'h01, 8'h11, 0, 1'b1, a);
        issue(1'b0, SLAVE_ID, 8'h02, 8'h22, 0, 1'b1, a2);
        chk("t6 accept gap", a2 - a, 29 * SLOT + 2);
        wait_idle();
        issue(1'b1, SLAVE_ID, 8'h01, 8'h00, 0, 1'b1, a);
        wait_idle();
        issue(1'b1, SLAVE_ID, 8'h02, 8'h00, 0, 1'b1, a);
        wait_idle();

        // Randomized traffic
        for (int n = 0; n < 14; n++) begin
            logic       rw;
            logic [6:0] dev;
            rw  = 1'($urandom);
            dev = SLAVE_ID;
            if ($urandom_range(3) == 0) begin
                dev = 7'($urandom);
                if (dev == SLAVE_ID) dev = 7'h51;
            end
            issue(rw, dev, 8'($urandom), 8'($urandom), 0, 1'b1, a);
            wait_idle();
        end

        chk("final scl_oe", int'(scl_oe), 0);
        chk("final sda_oe", int'(sda_oe), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
